egress_read_sched: RTL
======================

EGRESS_READ_SCHED -- requirements
Module: egress_read_sched

Interface
REQ-001 SHALL have parameter nr_of_queues, default 16: number of egress queues arbitrated.
REQ-002 SHALL have parameter burst_length, default 4: words read per grant; legal range 1..16.
REQ-003 SHALL have parameter rd_latency, default 3: cycles from the read_adr pulse to first valid egress q word.
REQ-004 SHALL have port clk, input, 1: single clock, shared with the egress FIFO read side (clk2).
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port fifo_empty, input, [0:nr_of_queues-1]: per-queue empty flags from the egress FIFO; low means at least one full burst is stored, because writers always push whole bursts.
REQ-007 SHALL have port ready, input, 1: downstream can accept one complete burst.
REQ-008 SHALL have port read_adr, output, 1: address-phase strobe to the egress FIFO.
REQ-009 SHALL have port read_data, output, 1: data-phase strobe to the egress FIFO.
REQ-010 SHALL have port read_enable, output, [0:nr_of_queues-1]: one-hot selection of the granted queue.
REQ-011 SHALL have port busy, output, 1: high while a burst is being issued.
REQ-012 SHALL have port q_valid, output, 1: egress q carries a valid word this cycle.
REQ-013 SHALL have port q_queue, output, 4: binary index of the queue whose word is on q while q_valid is high.
REQ-014 SHALL have port q_last, output, 1: final word of a burst, qualified by q_valid.

Function
REQ-015 SHALL implement the FSM states IDLE, ADR and DATA.
REQ-016 In IDLE, with ready=1 and at least one fifo_empty bit low, SHALL grant a queue and enter ADR on the next cycle; otherwise SHALL stay in IDLE.
REQ-017 SHALL choose the grant round-robin: the first non-empty queue strictly after the last granted index, wrapping from nr_of_queues-1 to 0; after reset the last-granted pointer is nr_of_queues-1, so queue 0 has top priority.
REQ-018 In ADR, SHALL assert read_adr=1 for exactly one cycle, with read_enable holding the grant's one-hot value.
REQ-019 From ADR, SHALL enter DATA if burst_length>1, else IDLE.
REQ-020 In DATA, SHALL assert read_data=1 for exactly burst_length-1 consecutive cycles, counted by a beat counter, then return to IDLE.
REQ-021 SHALL hold read_enable stable from ADR through the last DATA cycle, and SHALL drive it to all zeros in IDLE.
REQ-022 SHALL sample fifo_empty and ready only in IDLE; changes to either during ADR or DATA SHALL NOT abort or alter the burst.
REQ-023 SHALL insert a minimum gap of one IDLE cycle between consecutive bursts.
REQ-024 SHALL assert busy=1 in ADR and DATA, and busy=0 in IDLE.
REQ-025 SHALL delay each read strobe (read_adr or read_data) by rd_latency cycles through a shift register to form q_valid; q_queue and q_last SHALL travel in the same pipeline.
REQ-026 SHALL set q_last on the pipeline entry of the final strobe of each burst (read_adr when burst_length=1).
REQ-027 With all queues empty, or ready=0, SHALL issue no strobes.
REQ-028 SHALL never assert read_adr and read_data in the same cycle.

Reset
REQ-029 On rst=1, SHALL set: FSM to IDLE, read_adr=0, read_data=0, read_enable=0, busy=0, q_valid=0, q_queue=0, q_last=0, beat counter=0, latency pipeline cleared, last-granted pointer=nr_of_queues-1.
REQ-030 Reset asserted mid-burst SHALL abandon the burst immediately with no further strobes; FIFO pointer recovery is the responsibility of the egress FIFO's own reset.

Structure
REQ-031 SHALL take the FSM state encoding and a onehot2bin function from a shared package (egress_pkg), the function being common with the egress FIFO.
REQ-032 SHALL place the round-robin selector in one sub-module, rr_arbiter (inputs: request vector, last grant; output: one-hot grant), which is combinational; the pointer register stays in egress_read_sched.

Verification
REQ-033 SHALL verify: after reset, fifo_empty=16'hFFFF, ready=1 for 20 cycles -> no read_adr, read_data or q_valid.
REQ-034 SHALL verify: only queue 5 non-empty, ready=1 -> read_adr with read_enable=16'h0400 at cycle t+1, read_data at t+2..t+4, q_valid at t+4..t+7 with q_queue=5, and q_last at t+7.
REQ-035 SHALL verify: queues 0, 3 and 15 non-empty continuously -> grant order 0, 3, 15, 0, with a one-cycle IDLE gap between bursts.
REQ-036 SHALL verify: ready drops, or the granted queue's fifo_empty rises, during DATA -> the burst completes with all 4 strobes unchanged.
REQ-037 SHALL verify: rst pulsed on the second DATA cycle -> all outputs 0 in the same cycle, and after release the next grant is queue 0.
REQ-038 SHALL verify: burst_length=1 build -> ADR returns directly to IDLE, read_data is never asserted, and q_last accompanies every q_valid.

Source files
------------

// File: rtl/egress_pkg.sv
// -----------------------------------------------------------------------------
// egress_pkg
// Shared definitions for the egress path (read scheduler and egress FIFO).
//   MAX_QUEUES    : widest queue vector the shared helpers handle
//   QIDX_W        : width of a binary queue index
//   sched_state_t : read scheduler FSM encoding (IDLE, ADR, DATA)
//   onehot2bin()  : one-hot queue select to binary index
// -----------------------------------------------------------------------------
package egress_pkg;

    localparam int MAX_QUEUES = 16;
    localparam int QIDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADR  = 2'd1,
        DATA = 2'd2
    } sched_state_t;

    // OR-reduction of the set bit positions; exact for a one-hot input and
    // returns 0 for an all-zero input.
    function automatic logic [QIDX_W-1:0] onehot2bin(input logic [MAX_QUEUES-1:0] onehot);
        logic [QIDX_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_QUEUES; i++) begin
            if (onehot[i]) begin
                bin = bin | QIDX_W'(i);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/egress_read_sched_if.sv
// -----------------------------------------------------------------------------
// egress_read_sched_if
// Bundle between the egress FIFO read side / downstream and the read scheduler.
//   fifo_empty  : per-queue empty flags (index = queue number)
//   ready       : downstream can take one complete burst
//   read_adr    : address-phase strobe to the FIFO
//   read_data   : data-phase strobe to the FIFO
//   read_enable : one-hot granted queue (index = queue number)
//   busy        : burst in progress
//   q_valid     : FIFO output q carries a valid word
//   q_queue     : queue index of the word on q
//   q_last      : final word of a burst
// master = scheduler side, slave = FIFO / environment side.
// -----------------------------------------------------------------------------
interface egress_read_sched_if
    import egress_pkg::*;
#(
    parameter int nr_of_queues = 16
);

    logic [0:nr_of_queues-1] fifo_empty;
    logic                    ready;
    logic                    read_adr;
    logic                    read_data;
    logic [0:nr_of_queues-1] read_enable;
    logic                    busy;
    logic                    q_valid;
    logic [QIDX_W-1:0]       q_queue;
    logic                    q_last;

    modport master (
        input  fifo_empty, ready,
        output read_adr, read_data, read_enable, busy, q_valid, q_queue, q_last
    );

    modport slave (
        output fifo_empty, ready,
        input  read_adr, read_data, read_enable, busy, q_valid, q_queue, q_last
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector: picks the lowest requesting index that
// is strictly above last_grant, otherwise wraps to the lowest requester.
//   request    : [nr_of_queues-1:0] request vector (bit i = queue i)
//   last_grant : binary index of the previously granted queue
//   grant      : one-hot grant, all zeros when nothing requests
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int nr_of_queues = 16,
    parameter int idx_w        = 4
) (
    input  logic [nr_of_queues-1:0] request,
    input  logic [idx_w-1:0]        last_grant,
    output logic [nr_of_queues-1:0] grant
);

    logic [nr_of_queues-1:0] upper_req;
    logic [nr_of_queues-1:0] upper_pick;
    logic [nr_of_queues-1:0] wrap_pick;

    // Requests strictly after the last grant get first chance.
    generate
        for (genvar gi = 0; gi < nr_of_queues; gi++) begin : g_upper
            assign upper_req[gi] = request[gi] && (gi > int'(last_grant));
        end
    endgenerate

    // x & -x isolates the lowest set bit.
    assign upper_pick = upper_req & (~upper_req + nr_of_queues'(1));
    assign wrap_pick  = request   & (~request   + nr_of_queues'(1));

    assign grant = (|upper_req) ? upper_pick : wrap_pick;

endmodule

// File: rtl/egress_read_sched.sv
// -----------------------------------------------------------------------------
// egress_read_sched
// Round-robin read scheduler for the egress FIFO. When downstream is ready and
// some queue holds a burst, grants one queue and issues one read_adr strobe
// followed by burst_length-1 read_data strobes, then returns to IDLE for at
// least one cycle. Every strobe is delayed rd_latency cycles to mark the
// matching FIFO output word (q_valid / q_queue / q_last).
//   clk : clock shared with the FIFO read side
//   rst : asynchronous active-high reset
//   bus : egress_read_sched_if.master (see interface header)
// -----------------------------------------------------------------------------
module egress_read_sched
    import egress_pkg::*;
#(
    parameter int nr_of_queues = 16,
    parameter int burst_length = 4,
    parameter int rd_latency   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    egress_read_sched_if.master       bus
);

    localparam int                BEAT_W    = 5;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_length - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    logic [nr_of_queues-1:0] request;
    logic [nr_of_queues-1:0] grant;
    logic [MAX_QUEUES-1:0]   grant_wide;
    logic [QIDX_W-1:0]       grant_idx;

    sched_state_t            state_reg;
    logic                    read_adr_reg;
    logic                    read_data_reg;
    logic                    busy_reg;
    logic [nr_of_queues-1:0] read_enable_reg;
    logic [BEAT_W-1:0]       beat_reg;
    logic [QIDX_W-1:0]       last_grant_reg;

    logic [rd_latency-1:0]   valid_pipe_reg;
    logic [rd_latency-1:0]   last_pipe_reg;
    logic [QIDX_W-1:0]       queue_pipe_reg [rd_latency];

    logic                    strobe;
    logic                    strobe_last;

    // Port vectors are ascending [0:N-1]; internally bit i is queue i.
    generate
        for (genvar gi = 0; gi < nr_of_queues; gi++) begin : g_port_map
            assign request[gi]         = ~bus.fifo_empty[gi];
            assign bus.read_enable[gi] = read_enable_reg[gi];
        end
        for (genvar gi = 0; gi < MAX_QUEUES; gi++) begin : g_grant_wide
            if (gi < nr_of_queues) begin : g_used
                assign grant_wide[gi] = grant[gi];
            end else begin : g_unused
                assign grant_wide[gi] = 1'b0;
            end
        end
    endgenerate

    assign grant_idx = onehot2bin(grant_wide);

    rr_arbiter #(
        .nr_of_queues (nr_of_queues),
        .idx_w        (QIDX_W)
    ) u_rr_arbiter (
        .request    (request),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    // Inputs are only looked at in IDLE, so a burst once started always runs
    // to completion regardless of ready / fifo_empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            read_adr_reg    <= 1'b0;
            read_data_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            read_enable_reg <= '0;
            beat_reg        <= '0;
            last_grant_reg  <= QIDX_W'(nr_of_queues - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ready && (|request)) begin
                        state_reg       <= ADR;
                        read_adr_reg    <= 1'b1;
                        busy_reg        <= 1'b1;
                        read_enable_reg <= grant;
                        last_grant_reg  <= grant_idx;
                    end
                end
                ADR: begin
                    read_adr_reg <= 1'b0;
                    if (burst_length > 1) begin
                        state_reg     <= DATA;
                        read_data_reg <= 1'b1;
                        beat_reg      <= BEAT_ONE;
                    end else begin
                        state_reg       <= IDLE;
                        busy_reg        <= 1'b0;
                        read_enable_reg <= '0;
                    end
                end
                DATA: begin
                    // beat_reg numbers the data strobe currently on the bus.
                    if (beat_reg == LAST_BEAT) begin
                        state_reg       <= IDLE;
                        read_data_reg   <= 1'b0;
                        busy_reg        <= 1'b0;
                        read_enable_reg <= '0;
                        beat_reg        <= '0;
                    end else begin
                        beat_reg <= beat_reg + BEAT_ONE;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    read_adr_reg    <= 1'b0;
                    read_data_reg   <= 1'b0;
                    busy_reg        <= 1'b0;
                    read_enable_reg <= '0;
                    beat_reg        <= '0;
                end
            endcase
        end
    end

    assign strobe      = read_adr_reg | read_data_reg;
    assign strobe_last = (read_adr_reg && (burst_length == 1)) ||
                         (read_data_reg && (beat_reg == LAST_BEAT));

    // Latency pipeline: stage 0 captures the strobe registered this cycle, so
    // the last stage lines up with the FIFO's q rd_latency cycles later.
    // last_grant_reg holds the queue being read for the whole burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe_reg <= '0;
            last_pipe_reg  <= '0;
            for (int i = 0; i < rd_latency; i++) begin
                queue_pipe_reg[i] <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= strobe;
            last_pipe_reg[0]  <= strobe_last;
            queue_pipe_reg[0] <= strobe ? last_grant_reg : '0;
            for (int i = 1; i < rd_latency; i++) begin
                valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                last_pipe_reg[i]  <= last_pipe_reg[i-1];
                queue_pipe_reg[i] <= queue_pipe_reg[i-1];
            end
        end
    end

    assign bus.read_adr  = read_adr_reg;
    assign bus.read_data = read_data_reg;
    assign bus.busy      = busy_reg;
    assign bus.q_valid   = valid_pipe_reg[rd_latency-1];
    assign bus.q_last    = last_pipe_reg[rd_latency-1];
    assign bus.q_queue   = queue_pipe_reg[rd_latency-1];

endmodule
